// File: rtl/rv_pkg.sv
// Shared RV32 definitions used by fetch and decode: widths, NOP, opcodes,
// fetch FSM encoding and the fetch buffer entry layout.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory handshake, decode handoff and
// execute redirect. master = fetch unit, slave = its environment.
interface instr_fetch_unit_if;
  import rv_pkg::*;

  logic            IMemReq;
  logic [XLEN-1:0] IMemAddr;
  logic            IMemAck;
  logic [XLEN-1:0] IMemRData;

  logic            InstrValid;
  logic            InstrReady;
  logic [XLEN-1:0] Instr;
  logic [XLEN-1:0] InstrPC;

  logic            Redirect;
  logic [XLEN-1:0] RedirectPC;

  modport master (
    output IMemReq, IMemAddr, InstrValid, Instr, InstrPC,
    input  IMemAck, IMemRData, InstrReady, Redirect, RedirectPC
  );

  modport slave (
    input  IMemReq, IMemAddr, InstrValid, Instr, InstrPC,
    output IMemAck, IMemRData, InstrReady, Redirect, RedirectPC
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetched {instr, pc} entries. Head is read straight
// from storage registers; flush clears occupancy and beats push/pop.
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign count = count_reg;
  assign rdata = mem_reg[rd_ptr_reg];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_reg[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC ownership, single-outstanding memory reads,
// buffered hand-off to decode, and redirect with stale-response discard.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state_reg, state_next;
  logic [XLEN-1:0]  fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0]  addr_reg, addr_next;

  logic             ack;
  logic             pop;
  logic             push;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] occ_next;
  logic             issue_ok;

  fetch_entry_t     fifo_wdata;
  fetch_entry_t     fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_fifo_full;

  assign unused_fifo_full = fifo_full;

  // An ack only means something while a request is actually on the bus.
  assign ack         = bus.IMemAck && (state_reg != IDLE);
  assign pop         = bus.InstrReady && !fifo_empty;
  assign redirect_pc = word_align(bus.RedirectPC);
  assign fifo_wdata  = '{instr: bus.IMemRData, pc: addr_reg};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.Redirect),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    addr_next     = addr_reg;
    push          = 1'b0;
    occ_next      = '0;
    issue_ok      = 1'b0;

    if (state_reg == REQ && ack && !bus.Redirect) begin
      push          = 1'b1;
      fetch_pc_next = fetch_pc_reg + XLEN'(4);
    end
    if (bus.Redirect) fetch_pc_next = redirect_pc;

    // Occupancy after this edge; the new request itself needs one free slot.
    occ_next = bus.Redirect ? '0 : (fifo_count + CNT_W'(push) - CNT_W'(pop));
    issue_ok = (occ_next < CNT_W'(FIFO_DEPTH));

    unique case (state_reg)
      IDLE:    if (issue_ok) state_next = REQ;
      REQ: begin
        if (ack)               state_next = issue_ok ? REQ : IDLE;
        else if (bus.Redirect) state_next = DISCARD;
      end
      DISCARD: if (ack) state_next = REQ;
      default: state_next = IDLE;
    endcase

    // Address is frozen while a request is outstanding and not yet acked.
    if (!((state_reg != IDLE) && !ack)) addr_next = fetch_pc_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      addr_reg     <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      addr_reg     <= addr_next;
    end
  end

  assign bus.IMemReq    = (state_reg != IDLE);
  assign bus.IMemAddr   = addr_reg;
  assign bus.InstrValid = !fifo_empty;
  assign bus.Instr      = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign bus.InstrPC    = fifo_empty ? '0 : fifo_head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, back-pressure, slow memory,
// redirects, mid-transaction reset and PC wrap on a second instance.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  initial forever #5 clk = ~clk;

  instr_fetch_unit_if bus ();
  instr_fetch_unit_if bus2 ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int tests_run = 0;
  int tests_failed = 0;

  int          mem_delay = 0;
  int          slow_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] slow_addr = 32'hFFFF_FFFF;
  bit          spurious_ack = 1'b0;

  logic [31:0] consumed_pc[$];
  logic [31:0] consumed_instr[$];
  logic [31:0] acked_addr[$];
  logic [31:0] acked2_addr[$];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Memory for the main DUT: per-address wait states, optional ack with no request.
  initial begin
    bus.IMemAck = 1'b0;
    bus.IMemRData = '0;
    forever begin
      int d;
      @(negedge clk);
      #1;
      if (spurious_ack) begin
        bus.IMemAck = 1'b1;
        bus.IMemRData = 32'hDEAD_BEEF;
      end else if (bus.IMemReq) begin
        d = (bus.IMemAddr == slow_addr) ? slow_delay : mem_delay;
        if (wait_cnt >= d) begin
          bus.IMemAck = 1'b1;
          bus.IMemRData = data_of(bus.IMemAddr);
          wait_cnt = 0;
        end else begin
          bus.IMemAck = 1'b0;
          bus.IMemRData = '0;
          wait_cnt++;
        end
      end else begin
        bus.IMemAck = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Zero-wait memory and always-ready decode for the wrap instance.
  initial begin
    bus2.IMemAck = 1'b0;
    bus2.IMemRData = '0;
    bus2.InstrReady = 1'b1;
    bus2.Redirect = 1'b0;
    bus2.RedirectPC = '0;
    forever begin
      @(negedge clk);
      #1;
      bus2.IMemAck = bus2.IMemReq;
      bus2.IMemRData = data_of(bus2.IMemAddr);
    end
  end

  // Transaction recorder, sampled mid low phase.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (bus.IMemReq && bus.IMemAck) acked_addr.push_back(bus.IMemAddr);
      if (bus.InstrValid && bus.InstrReady) begin
        consumed_pc.push_back(bus.InstrPC);
        consumed_instr.push_back(bus.Instr);
        $display("[TB] t=%0t decode pc=%h instr=%h", $time, bus.InstrPC, bus.Instr);
      end
      if (bus2.IMemReq && bus2.IMemAck) acked2_addr.push_back(bus2.IMemAddr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic ready);
    rst_n = 1'b0;
    bus.Redirect = 1'b0;
    bus.RedirectPC = '0;
    bus.InstrReady = ready;
    repeat (2) @(negedge clk);
    consumed_pc.delete();
    consumed_instr.delete();
    acked_addr.delete();
    acked2_addr.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.InstrReady = 1'b0;
    bus.Redirect = 1'b0;
    bus.RedirectPC = '0;
    repeat (2) @(negedge clk);
    tests_run++; if (bus.IMemReq !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b required 0", bus.IMemReq); end
    tests_run++; if (bus.IMemAddr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h required 0", bus.IMemAddr); end
    tests_run++; if (bus.InstrValid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b required 0", bus.InstrValid); end
    tests_run++; if (bus.Instr !== 32'h0000_0013) begin tests_failed++; $display("FAIL reset_instr: got %h required 00000013", bus.Instr); end
    tests_run++; if (bus.InstrPC !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h required 0", bus.InstrPC); end
    tests_run++; if (bus2.IMemAddr !== 32'hFFFF_FFF8) begin tests_failed++; $display("FAIL reset_addr_wrapdut: got %h required fffffff8", bus2.IMemAddr); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h0) begin tests_failed++; $display("FAIL first_req: got req=%b addr=%h required req=1 addr=0", bus.IMemReq, bus.IMemAddr); end
  endtask

  task automatic test_stream();
    mem_delay = 0;
    slow_addr = 32'hFFFF_FFFF;
    do_reset(1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'(4 * (k - 1))) begin
        tests_failed++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h required req=1 addr=%h", k, bus.IMemReq, bus.IMemAddr, 32'(4 * (k - 1)));
      end
      if (k >= 2) begin
        tests_run++;
        if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 32'(4 * (k - 2)) || bus.Instr !== data_of(32'(4 * (k - 2)))) begin
          tests_failed++; $display("FAIL stream_out[%0d]: got v=%b pc=%h instr=%h required v=1 pc=%h instr=%h", k, bus.InstrValid, bus.InstrPC, bus.Instr, 32'(4 * (k - 2)), data_of(32'(4 * (k - 2))));
        end
      end
    end
  endtask

  task automatic test_stall();
    mem_delay = 0;
    slow_addr = 32'hFFFF_FFFF;
    do_reset(1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        tests_run++;
        if (bus.IMemReq !== 1'b0 || bus.InstrValid !== 1'b1 || bus.InstrPC !== 32'h0 || bus.Instr !== data_of(32'h0)) begin
          tests_failed++; $display("FAIL stall_hold[%0d]: got req=%b v=%b pc=%h instr=%h required req=0 v=1 pc=0 instr=%h", k, bus.IMemReq, bus.InstrValid, bus.InstrPC, bus.Instr, data_of(32'h0));
        end
      end
    end
    tests_run++; if (acked_addr.size() !== 2) begin tests_failed++; $display("FAIL stall_buffered: got %0d acks required 2", acked_addr.size()); end
    bus.InstrReady = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++;
    if (consumed_pc.size() < 3) begin
      tests_failed++; $display("FAIL stall_drain_count: got %0d required at least 3", consumed_pc.size());
    end else if (consumed_pc[0] !== 32'h0 || consumed_pc[1] !== 32'h4 || consumed_pc[2] !== 32'h8 || consumed_instr[2] !== data_of(32'h8)) begin
      tests_failed++; $display("FAIL stall_drain_order: got %h %h %h required 0 4 8", consumed_pc[0], consumed_pc[1], consumed_pc[2]);
    end
  endtask

  task automatic test_delay();
    mem_delay = 3;
    slow_addr = 32'hFFFF_FFFF;
    do_reset(1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h0 || bus.InstrValid !== 1'b0) begin
        tests_failed++; $display("FAIL delay_hold[%0d]: got req=%b addr=%h v=%b required req=1 addr=0 v=0", k, bus.IMemReq, bus.IMemAddr, bus.InstrValid);
      end
    end
    @(negedge clk);
    tests_run++;
    if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 32'h0 || bus.Instr !== data_of(32'h0)) begin
      tests_failed++; $display("FAIL delay_out: got v=%b pc=%h instr=%h required v=1 pc=0 instr=%h", bus.InstrValid, bus.InstrPC, bus.Instr, data_of(32'h0));
    end
    mem_delay = 0;
  endtask

  task automatic test_redirect();
    bit saw_stale;
    mem_delay = 0;
    slow_addr = 32'h8;
    slow_delay = 2;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    tests_run++; if (bus.IMemAddr !== 32'h8) begin tests_failed++; $display("FAIL redir_pre_addr: got %h required 8", bus.IMemAddr); end
    bus.Redirect = 1'b1;
    bus.RedirectPC = 32'h0000_0103;
    @(negedge clk);
    bus.Redirect = 1'b0;
    tests_run++;
    if (bus.InstrValid !== 1'b0 || bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h8) begin
      tests_failed++; $display("FAIL redir_flush: got v=%b req=%b addr=%h required v=0 req=1 addr=8", bus.InstrValid, bus.IMemReq, bus.IMemAddr);
    end
    @(negedge clk);
    tests_run++; if (bus.IMemAddr !== 32'h8) begin tests_failed++; $display("FAIL redir_stale_hold: got %h required 8", bus.IMemAddr); end
    @(negedge clk);
    tests_run++;
    if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h100 || bus.InstrValid !== 1'b0) begin
      tests_failed++; $display("FAIL redir_new_req: got req=%b addr=%h v=%b required req=1 addr=100 v=0", bus.IMemReq, bus.IMemAddr, bus.InstrValid);
    end
    @(negedge clk);
    tests_run++;
    if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 32'h100 || bus.Instr !== data_of(32'h100)) begin
      tests_failed++; $display("FAIL redir_target_out: got v=%b pc=%h instr=%h required v=1 pc=100 instr=%h", bus.InstrValid, bus.InstrPC, bus.Instr, data_of(32'h100));
    end
    @(negedge clk);
    saw_stale = 1'b0;
    foreach (consumed_pc[i]) if (consumed_pc[i] === 32'h8) saw_stale = 1'b1;
    tests_run++; if (saw_stale !== 1'b0) begin tests_failed++; $display("FAIL redir_stale_seen: got stale pc 8 presented required never"); end
    slow_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_redirect_ack_pop();
    mem_delay = 0;
    slow_addr = 32'hFFFF_FFFF;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    tests_run++; if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 32'h4) begin tests_failed++; $display("FAIL rap_pre: got v=%b pc=%h required v=1 pc=4", bus.InstrValid, bus.InstrPC); end
    bus.Redirect = 1'b1;
    bus.RedirectPC = 32'h0000_0200;
    @(negedge clk);
    bus.Redirect = 1'b0;
    tests_run++;
    if (bus.IMemAddr !== 32'h200 || bus.IMemReq !== 1'b1 || bus.InstrValid !== 1'b0) begin
      tests_failed++; $display("FAIL rap_next_req: got req=%b addr=%h v=%b required req=1 addr=200 v=0", bus.IMemReq, bus.IMemAddr, bus.InstrValid);
    end
    @(negedge clk);
    tests_run++;
    if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 32'h200 || bus.Instr !== data_of(32'h200)) begin
      tests_failed++; $display("FAIL rap_target_out: got v=%b pc=%h instr=%h required v=1 pc=200 instr=%h", bus.InstrValid, bus.InstrPC, bus.Instr, data_of(32'h200));
    end
    @(negedge clk);
    tests_run++;
    if (consumed_pc.size() < 3 || acked_addr.size() < 3) begin
      tests_failed++; $display("FAIL rap_counts: got consumed=%0d acked=%0d required at least 3 each", consumed_pc.size(), acked_addr.size());
    end else if (consumed_pc[1] !== 32'h4 || consumed_pc[2] !== 32'h200 || acked_addr[2] !== 32'h8) begin
      tests_failed++; $display("FAIL rap_sequence: got consumed %h %h acked %h required 4 200 acked 8", consumed_pc[1], consumed_pc[2], acked_addr[2]);
    end
  endtask

  task automatic test_reset_mid();
    mem_delay = 0;
    slow_addr = 32'h4;
    slow_delay = 5;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h4 || bus.InstrValid !== 1'b1) begin
      tests_failed++; $display("FAIL rmid_pre: got req=%b addr=%h v=%b required req=1 addr=4 v=1", bus.IMemReq, bus.IMemAddr, bus.InstrValid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.IMemReq !== 1'b0 || bus.InstrValid !== 1'b0 || bus.Instr !== 32'h0000_0013 || bus.InstrPC !== 32'h0 || bus.IMemAddr !== 32'h0) begin
      tests_failed++; $display("FAIL rmid_async: got req=%b v=%b instr=%h pc=%h addr=%h required 0 0 00000013 0 0", bus.IMemReq, bus.InstrValid, bus.Instr, bus.InstrPC, bus.IMemAddr);
    end
    slow_addr = 32'hFFFF_FFFF;
    bus.InstrReady = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spurious_ack = 1'b1;
    @(negedge clk);
    spurious_ack = 1'b0;
    tests_run++;
    if (bus.InstrValid !== 1'b0 || bus.IMemReq !== 1'b1 || bus.IMemAddr !== 32'h0) begin
      tests_failed++; $display("FAIL rmid_late_ack: got v=%b req=%b addr=%h required v=0 req=1 addr=0", bus.InstrValid, bus.IMemReq, bus.IMemAddr);
    end
    @(negedge clk);
    tests_run++;
    if (bus.InstrValid !== 1'b1 || bus.InstrPC !== 32'h0 || bus.Instr !== data_of(32'h0)) begin
      tests_failed++; $display("FAIL rmid_restart: got v=%b pc=%h instr=%h required v=1 pc=0 instr=%h", bus.InstrValid, bus.InstrPC, bus.Instr, data_of(32'h0));
    end
  endtask

  task automatic test_wrap();
    mem_delay = 0;
    slow_addr = 32'hFFFF_FFFF;
    do_reset(1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) begin
        tests_run++;
        if (bus2.InstrValid !== 1'b1 || bus2.InstrPC !== 32'h0 || bus2.Instr !== data_of(32'h0)) begin
          tests_failed++; $display("FAIL wrap_out: got v=%b pc=%h instr=%h required v=1 pc=0 instr=%h", bus2.InstrValid, bus2.InstrPC, bus2.Instr, data_of(32'h0));
        end
      end
    end
    tests_run++;
    if (acked2_addr.size() < 3) begin
      tests_failed++; $display("FAIL wrap_count: got %0d acks required at least 3", acked2_addr.size());
    end else if (acked2_addr[0] !== 32'hFFFF_FFF8 || acked2_addr[1] !== 32'hFFFF_FFFC || acked2_addr[2] !== 32'h0) begin
      tests_failed++; $display("FAIL wrap_seq: got %h %h %h required fffffff8 fffffffc 00000000", acked2_addr[0], acked2_addr[1], acked2_addr[2]);
    end
  endtask

  initial begin
    bus.InstrReady = 1'b0;
    bus.Redirect = 1'b0;
    bus.RedirectPC = '0;
    test_reset();
    test_stream();
    test_stall();
    test_delay();
    test_redirect();
    test_redirect_ack_pop();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
